uart_cmd_sched: RTL and testbench

Shares the single command UART transmitter (uart_tx: trmt / tx_data / tx_done) between two command requesters, e.g. a scripted test sequencer and a rider/BLE stimulus driver.
Accepted bytes go into a shared FIFO in arbitration order, then go out one at a time. Each byte is launched only after the previous byte completes, followed by a guaranteed idle gap.
Sits between requesters and uart_tx, giving back-to-back Segway commands such as 'g' (0x67) and 's' (0x73).

---
 rtl/uart_cmd_sched.sv | 114 +++++++++++
 tb/tb_uart_cmd_sched.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sched.sv
// Two-requester command scheduler in front of a single uart_tx.
// Bytes are queued in arbitration order and launched one at a time, with an idle gap after each completion.
module uart_cmd_sched #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_vld,
    input  logic [7:0]               req0_data,
    output logic                     req0_rdy,
    input  logic                     req1_vld,
    input  logic [7:0]               req1_data,
    output logic                     req1_rdy,
    output logic                     trmt,
    output logic [7:0]               tx_data,
    input  logic                     tx_done,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] GAP    = 2'd3;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic [1:0]    state;
    logic [GW-1:0] gap_cnt;
    logic          last_grant;
    logic          full;
    logic          push;
    logic          pop;
    logic [7:0]    push_data;

    // Full comes from the registered count, so a same-cycle pop never frees room.
    assign full      = (cnt == CW'(DEPTH));
    assign req0_rdy  = !full && req0_vld && (!req1_vld || last_grant);
    assign req1_rdy  = !full && req1_vld && (!req0_vld || !last_grant);
    assign push      = req0_rdy || req1_rdy;
    assign push_data = req0_rdy ? req0_data : req1_data;
    assign pop       = (state == LAUNCH);

    assign fifo_cnt  = cnt;
    assign busy      = (cnt != '0) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else begin
            if (push) begin
                wptr       <= wptr + 1'b1;
                last_grant <= req1_rdy;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            trmt    <= 1'b0;
            tx_data <= 8'h00;
            gap_cnt <= '0;
        end else begin
            trmt <= 1'b0;
            case (state)
                IDLE: begin
                    // Head is captured on entry so tx_data is valid alongside trmt.
                    if (cnt != '0) begin
                        state   <= LAUNCH;
                        trmt    <= 1'b1;
                        tx_data <= mem[rptr];
                    end
                end
                LAUNCH: state <= WAIT;
                WAIT: begin
                    if (tx_done) begin
                        state   <= GAP;
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                    end
                end
                default: begin
                    if (gap_cnt == '0)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Randomized bench for uart_cmd_sched against a timestamp/queue reference model.
module tb_uart_cmd_sched;

    localparam int DEPTH = 4;
    localparam int GAP   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_vld, req1_vld, req0_rdy, req1_rdy;
    logic [7:0] req0_data, req1_data, tx_data;
    logic       trmt, tx_done, busy;
    logic [2:0] fifo_cnt;

    uart_cmd_sched #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_data(req0_data), .req0_rdy(req0_rdy),
        .req1_vld(req1_vld), .req1_data(req1_data), .req1_rdy(req1_rdy),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
        .fifo_cnt(fifo_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of pending bytes plus a few timestamps.
    logic [7:0] q[$];
    logic       m_last;       // 1 -> requester 0 wins a tie
    logic       in_flight;    // launched byte not yet completed
    logic       pend_pop;     // byte launched at previous edge, removed at this edge
    int         ready_at;     // earliest edge at which a launch may happen
    logic       m_trmt;
    logic [7:0] m_txd;
    int         e = 0;
    logic       m_r0, m_r1;

    task automatic model_reset();
        q.delete();
        m_last    = 1'b1;
        in_flight = 1'b0;
        pend_pop  = 1'b0;
        ready_at  = 0;
        m_trmt    = 1'b0;
        m_txd     = 8'h00;
    endtask

    task automatic model_rdy();
        logic full;
        full = (q.size() == DEPTH);
        m_r0 = !full && req0_vld && (!req1_vld || m_last);
        m_r1 = !full && req1_vld && (!req0_vld || !m_last);
    endtask

    task automatic model_edge();
        logic launch, done, dpop;
        if (rst) begin
            model_reset();
            return;
        end
        dpop   = pend_pop;
        launch = !in_flight && (e >= ready_at) && (q.size() != 0);
        done   = tx_done && in_flight && !pend_pop;
        if (done) begin
            in_flight = 1'b0;
            ready_at  = e + GAP + 1;
        end
        m_trmt = 1'b0;
        if (launch) begin
            m_txd     = q[0];
            m_trmt    = 1'b1;
            in_flight = 1'b1;
            pend_pop  = 1'b1;
        end
        if (dpop) begin
            void'(q.pop_front());
            pend_pop = 1'b0;
        end
        if (m_r0) begin
            q.push_back(req0_data);
            m_last = 1'b0;
        end else if (m_r1) begin
            q.push_back(req1_data);
            m_last = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic exp_busy;
        exp_busy = (q.size() != 0) || in_flight || (e + 1 < ready_at);
        chk("trmt", 32'(trmt), 32'(m_trmt));
        chk("tx_data", 32'(tx_data), 32'(m_txd));
        chk("fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
        chk("busy", 32'(busy), 32'(exp_busy));
    endtask

    initial begin
        int pv, pd, pr;
        rst = 1'b1; req0_vld = 0; req1_vld = 0; req0_data = 0; req1_data = 0; tx_done = 0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        chk("rst_cnt", 32'(fifo_cnt), 0);
        chk("rst_trmt", 32'(trmt), 0);
        chk("rst_txd", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);

        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0:       begin pv = 90; pd = 2;  pr = 0;   end
                1:       begin pv = 30; pd = 20; pr = 300; end
                2:       begin pv = 95; pd = 10; pr = 150; end
                default: begin pv = 10; pd = 50; pr = 400; end
            endcase
            for (int c = 0; c < 1500; c++) begin
                @(negedge clk);
                rst       = (pr != 0) && ($urandom_range(pr - 1) == 0);
                req0_vld  = ($urandom_range(99) < pv);
                req1_vld  = ($urandom_range(99) < pv);
                req0_data = 8'($urandom);
                req1_data = 8'($urandom);
                tx_done   = ($urandom_range(99) < pd);
                #1;
                model_rdy();
                chk("req0_rdy", 32'(req0_rdy), 32'(m_r0));
                chk("req1_rdy", 32'(req1_rdy), 32'(m_r1));
                @(posedge clk);
                e++;
                model_edge();
                #1;
                check_outputs();
            end
        end

        @(negedge clk);
        rst = 1'b0; req0_vld = 0; req1_vld = 0; tx_done = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
